filt_dec_40mhz: RTL and testbench

- Front end of the 40 MHz compatibility triggers (ToTd, threshold, MoPS).
- Applies a fixed 21-tap symmetric low-pass FIR to each of the three 120 MHz PMT ADC streams and decimates by 3.
- Generates the shared ENABLE40 phase count. Consumers sample the filtered outputs and their deconvolution/integral stages when ENABLE40==0.

---
 rtl/filt_dec_40mhz_pkg.sv | 25 ++
 rtl/filt_dec_40mhz_chan.sv | 128 ++++++++++++
 rtl/filt_dec_40mhz.sv | 90 +++++++++
 tb/tb_filt_dec_40mhz.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/filt_dec_40mhz_pkg.sv
// Shared constants for the 40 MHz compatibility-trigger front end.
// Holds the symmetric low-pass coefficient table, scaling and latency figures.
// No logic; imported by the filter channel and the top level.
package filt_dec_40mhz_pkg;

  localparam int ADC_W               = 12;
  localparam int ADC_MAX             = (1 << ADC_W) - 1;
  localparam int COEF_W              = 12;
  localparam int COMPAT_FILT_NTAPS   = 21;
  localparam int COMPAT_FILT_SHIFT   = 11;
  localparam int COMPAT_FILT_LATENCY = 14;
  localparam int COMPAT_FILT_ACC_W   = 26;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic [ADC_W-1:0]         sample_t;
  typedef logic [1:0]               phase_t;

  // Coefficients sum to 2^COMPAT_FILT_SHIFT, so the filter has unity DC gain.
  localparam coef_t COMPAT_FILT_COEF [COMPAT_FILT_NTAPS] = '{
    12'sd5,    12'sd0,    12'sd12,   12'sd22,  12'sd0,   -12'sd61, -12'sd96,
    12'sd0,    12'sd256,  12'sd551,  12'sd670, 12'sd551, 12'sd256, 12'sd0,
    -12'sd96,  -12'sd61,  12'sd0,    12'sd22,  12'sd12,  12'sd0,   12'sd5
  };

endpackage

// File: rtl/filt_dec_40mhz_chan.sv
// One channel of the 21-tap symmetric FIR: delay line, pre-add, multiply, 2-level adder tree, round/clip.
// Latency: sample registered at edge n is the centre tap of the sum held after edge n+14.
// No backpressure: the pipeline advances every clock; round/clip is combinational off the sum register.
module fir21_chan
  import filt_dec_40mhz_pkg::*;
#(
  parameter int NTAPS      = COMPAT_FILT_NTAPS,
  parameter int COEF_SHIFT = COMPAT_FILT_SHIFT,
  parameter int ACC_W      = COMPAT_FILT_ACC_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [ADC_W-1:0] adc_i,
  output logic [ADC_W-1:0] y_o,
  output logic             ovf_o,
  output logic [ADC_W-1:0] raw_o
);

  localparam int HALF  = NTAPS / 2;
  localparam int NPROD = HALF + 1;
  localparam int GRP   = 4;
  localparam int NGRP  = (NPROD + GRP - 1) / GRP;
  localparam int NPAD  = NGRP * GRP;
  localparam int PRE_W = ADC_W + 2;
  localparam int RAW_STAGES = 4;

  logic [ADC_W-1:0]        tap_q  [NTAPS];
  logic signed [PRE_W-1:0] pre_q  [NPROD];
  logic signed [ACC_W-1:0] prod_d [NPAD];
  logic signed [ACC_W-1:0] prod_q [NPAD];
  logic signed [ACC_W-1:0] grp_d  [NGRP];
  logic signed [ACC_W-1:0] grp_q  [NGRP];
  logic signed [ACC_W-1:0] sum_d;
  logic signed [ACC_W-1:0] sum_q;
  logic [ADC_W-1:0]        raw_q  [RAW_STAGES];
  logic signed [ACC_W:0]   rnd;

  // S0: shift the new sample into the head of the delay line
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NTAPS; i++) tap_q[i] <= '0;
    end else begin
      tap_q[0] <= adc_i;
      for (int i = 1; i < NTAPS; i++) tap_q[i] <= tap_q[i-1];
    end
  end

  // S1: fold symmetric tap pairs; the centre tap passes through unpaired
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NPROD; k++) pre_q[k] <= '0;
    end else begin
      for (int k = 0; k < HALF; k++)
        pre_q[k] <= PRE_W'(tap_q[k]) + PRE_W'(tap_q[NTAPS-1-k]);
      pre_q[HALF] <= PRE_W'(tap_q[HALF]);
    end
  end

  // S2 products; zero coefficients and the padding slots stay constant zero so synthesis drops them
  always_comb begin
    for (int k = 0; k < NPAD; k++) prod_d[k] = '0;
    for (int k = 0; k < NPROD; k++) begin
      if (COMPAT_FILT_COEF[k] != '0)
        prod_d[k] = ACC_W'(pre_q[k]) * ACC_W'(COMPAT_FILT_COEF[k]);
    end
  end

  // S2: register the products
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NPAD; k++) prod_q[k] <= '0;
    end else begin
      for (int k = 0; k < NPAD; k++) prod_q[k] <= prod_d[k];
    end
  end

  // First adder level: groups of four products
  always_comb begin
    for (int g = 0; g < NGRP; g++) begin
      grp_d[g] = '0;
      for (int i = 0; i < GRP; i++) grp_d[g] = grp_d[g] + prod_q[g*GRP+i];
    end
  end

  // Second adder level: combine the group sums
  always_comb begin
    sum_d = '0;
    for (int g = 0; g < NGRP; g++) sum_d = sum_d + grp_q[g];
  end

  // S3/S4: registered adder tree
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int g = 0; g < NGRP; g++) grp_q[g] <= '0;
      sum_q <= '0;
    end else begin
      for (int g = 0; g < NGRP; g++) grp_q[g] <= grp_d[g];
      sum_q <= sum_d;
    end
  end

  // Carry the raw centre-tap sample alongside S1..S4 so bypass has the same latency as the filter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < RAW_STAGES; i++) raw_q[i] <= '0;
    end else begin
      raw_q[0] <= tap_q[HALF];
      for (int i = 1; i < RAW_STAGES; i++) raw_q[i] <= raw_q[i-1];
    end
  end

  // Round half up, arithmetic shift, then clip into the unsigned ADC range
  always_comb begin
    rnd   = ((ACC_W+1)'(sum_q) + (ACC_W+1)'(1 << (COEF_SHIFT-1))) >>> COEF_SHIFT;
    y_o   = rnd[ADC_W-1:0];
    ovf_o = 1'b0;
    if (rnd[ACC_W]) begin
      y_o   = '0;
      ovf_o = 1'b1;
    end else if (rnd[ACC_W-1:ADC_W] != '0) begin
      y_o   = '1;
      ovf_o = 1'b1;
    end
  end

  assign raw_o = raw_q[RAW_STAGES-1];

endmodule

// File: rtl/filt_dec_40mhz.sv
// 40 MHz trigger front end: three FIR channels decimated by 3, plus the shared ENABLE40 phase count.
// Latency: filter result for a sample is in the channel sum 14 edges later; captured on the next wrap to phase 0.
// No backpressure: outputs are held between captures; SYNC forces an early wrap (capture on its first cycle only).
module filt_dec_40mhz
  import filt_dec_40mhz_pkg::*;
#(
  parameter int NTAPS      = COMPAT_FILT_NTAPS,
  parameter int COEF_SHIFT = COMPAT_FILT_SHIFT,
  parameter int ACC_W      = COMPAT_FILT_ACC_W
) (
  input  logic             CLK120,
  input  logic             RESET,
  input  logic             SYNC,
  input  logic             BYPASS,
  input  logic [ADC_W-1:0] ADC0,
  input  logic [ADC_W-1:0] ADC1,
  input  logic [ADC_W-1:0] ADC2,
  output logic [1:0]       ENABLE40,
  output logic [ADC_W-1:0] ADC0_FILT,
  output logic [ADC_W-1:0] ADC1_FILT,
  output logic [ADC_W-1:0] ADC2_FILT,
  output logic [2:0]       OVF
);

  localparam int NCH = 3;
  localparam phase_t PHASE_LAST = 2'd2;

  logic [ADC_W-1:0] adc    [NCH];
  logic [ADC_W-1:0] y      [NCH];
  logic [ADC_W-1:0] raw    [NCH];
  logic [NCH-1:0]   ovf_c;
  logic [ADC_W-1:0] filt_q [NCH];
  logic [NCH-1:0]   ovf_q;
  phase_t           phase_q;
  phase_t           phase_d;
  logic             sync_q;
  logic             capture;

  assign adc[0] = ADC0;
  assign adc[1] = ADC1;
  assign adc[2] = ADC2;

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    fir21_chan #(
      .NTAPS      (NTAPS),
      .COEF_SHIFT (COEF_SHIFT),
      .ACC_W      (ACC_W)
    ) u_chan (
      .clk_i (CLK120),
      .rst_i (RESET),
      .adc_i (adc[c]),
      .y_o   (y[c]),
      .ovf_o (ovf_c[c]),
      .raw_o (raw[c])
    );
  end

  // Next phase and capture strobe: natural 2->0 wrap, or the first cycle of a SYNC assertion
  always_comb begin
    phase_d = phase_q + 2'd1;
    if (SYNC || phase_q == PHASE_LAST) phase_d = '0;
    capture = (phase_q == PHASE_LAST) || (SYNC && !sync_q);
  end

  // Phase counter and output capture; BYPASS is sampled at the capture edge itself
  always_ff @(posedge CLK120) begin
    if (RESET) begin
      phase_q <= '0;
      sync_q  <= 1'b0;
      ovf_q   <= '0;
      for (int c = 0; c < NCH; c++) filt_q[c] <= '0;
    end else begin
      phase_q <= phase_d;
      sync_q  <= SYNC;
      if (capture) begin
        for (int c = 0; c < NCH; c++) begin
          filt_q[c] <= BYPASS ? raw[c] : y[c];
          ovf_q[c]  <= !BYPASS && ovf_c[c];
        end
      end
    end
  end

  assign ENABLE40  = phase_q;
  assign ADC0_FILT = filt_q[0];
  assign ADC1_FILT = filt_q[1];
  assign ADC2_FILT = filt_q[2];
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_filt_dec_40mhz.sv
// Bench for filt_dec_40mhz: convolution reference model checked every cycle plus directed scenarios.
module tb_filt_dec_40mhz;

  localparam int NT    = 21;
  localparam int SH    = 11;
  localparam int XMAX  = 4096;
  localparam int COEF [NT] = '{5, 0, 12, 22, 0, -61, -96, 0, 256, 551, 670,
                               551, 256, 0, -96, -61, 0, 22, 12, 0, 5};

  logic        clk = 1'b0;
  logic        RESET, SYNC, BYPASS;
  logic [11:0] a0, a1, a2;
  logic [1:0]  ENABLE40;
  logic [11:0] ADC0_FILT, ADC1_FILT, ADC2_FILT;
  logic [2:0]  OVF;

  int n_checks = 0;
  int n_err    = 0;

  filt_dec_40mhz dut (
    .CLK120    (clk),
    .RESET     (RESET),
    .SYNC      (SYNC),
    .BYPASS    (BYPASS),
    .ADC0      (a0),
    .ADC1      (a1),
    .ADC2      (a2),
    .ENABLE40  (ENABLE40),
    .ADC0_FILT (ADC0_FILT),
    .ADC1_FILT (ADC1_FILT),
    .ADC2_FILT (ADC2_FILT),
    .OVF       (OVF)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int x [3][XMAX];
  int ecount   = 0;
  int last_rst = -1;
  int ph_m     = 0;
  bit sp_m     = 1'b0;
  int ef [3]   = '{0, 0, 0};
  int eo [3]   = '{0, 0, 0};
  bit active   = 1'b0;

  function automatic int xv(input int ch, input int t);
    if (t < 0 || t <= last_rst) return 0;
    return x[ch][t];
  endfunction

  // Unscaled filter sum visible after edge e: its centre tap is the sample taken at edge e-14
  function automatic int conv(input int ch, input int e);
    int s = 0;
    for (int j = 0; j < NT; j++) s += COEF[j] * xv(ch, e - 4 - j);
    return s;
  endfunction

  function automatic int rnd_y(input int s);
    int y = (s + (1 << (SH-1))) >>> SH;
    if (y < 0) return 0;
    if (y > 4095) return 4095;
    return y;
  endfunction

  function automatic int rnd_o(input int s);
    int y = (s + (1 << (SH-1))) >>> SH;
    return (y < 0 || y > 4095) ? 1 : 0;
  endfunction

  always @(posedge clk) begin
    int  e;
    bit  cap;
    int  s;
    e = ecount;
    if (RESET) begin
      last_rst = e;
      for (int c = 0; c < 3; c++) begin x[c][e] = 0; ef[c] = 0; eo[c] = 0; end
      ph_m = 0; sp_m = 1'b0; active = 1'b1;
    end else begin
      x[0][e] = a0; x[1][e] = a1; x[2][e] = a2;
      cap = (ph_m == 2) || (SYNC && !sp_m);
      if (cap) begin
        for (int c = 0; c < 3; c++) begin
          if (BYPASS) begin
            ef[c] = xv(c, e - 15); eo[c] = 0;
          end else begin
            s = conv(c, e - 1); ef[c] = rnd_y(s); eo[c] = rnd_o(s);
          end
        end
      end
      ph_m = (SYNC || ph_m == 2) ? 0 : ph_m + 1;
      sp_m = SYNC;
    end
    ecount++;
  end

  always @(posedge clk) begin
    #1;
    if (active) begin
      chk("enable40", ENABLE40, ph_m);
      chk("adc0_filt", ADC0_FILT, ef[0]);
      chk("adc1_filt", ADC1_FILT, ef[1]);
      chk("adc2_filt", ADC2_FILT, ef[2]);
      chk("ovf", OVF, eo[2]*4 + eo[1]*2 + eo[0]);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_en(input int v);
    int n = 0;
    while (ENABLE40 != v && n < 10) begin @(negedge clk); n++; end
    if (ENABLE40 != v) chk("wait_enable40", ENABLE40, v);
  endtask

  task automatic impulse(input int off, output bit s327, output bit s269,
                         output bit s11, output bit sclip, output bit other);
    s327 = 0; s269 = 0; s11 = 0; sclip = 0; other = 0;
    a0 = 0; a1 = 0; a2 = 0;
    repeat (30) @(negedge clk);
    wait_en(2);
    repeat (off) @(negedge clk);
    a0 = 12'd1000;
    @(negedge clk);
    a0 = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ADC0_FILT == 327) s327 = 1;
      if (ADC0_FILT == 269) s269 = 1;
      if (ADC0_FILT == 11) s11 = 1;
      if (ADC0_FILT == 0 && OVF[0]) sclip = 1;
      if (ADC1_FILT != 0 || ADC2_FILT != 0) other = 1;
    end
  endtask

  initial begin
    bit s327, s269, s11, sclip, other, seen_hi;
    RESET = 1; SYNC = 0; BYPASS = 0; a0 = 0; a1 = 0; a2 = 0;
    repeat (3) @(negedge clk);
    chk("reset_enable40", ENABLE40, 0);
    chk("reset_filt0", ADC0_FILT, 0);
    chk("reset_filt2", ADC2_FILT, 0);
    chk("reset_ovf", OVF, 0);
    RESET = 0;

    // hand-computed pins for the model's scaling
    chk("pin_centre", rnd_y(670 * 1000), 327);
    chk("pin_tap22", rnd_y(22 * 1000), 11);
    chk("pin_neg_y", rnd_y(-96 * 1000), 0);
    chk("pin_neg_ovf", rnd_o(-96 * 1000), 1);
    chk("pin_dc", rnd_y(500 * 2048), 500);
    chk("pin_hi_ovf", rnd_o(4095 * 2166), 1);

    // DC
    a0 = 500; a1 = 500; a2 = 500;
    repeat (30) @(negedge clk);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("dc_filt0", ADC0_FILT, 500);
      chk("dc_filt1", ADC1_FILT, 500);
      chk("dc_filt2", ADC2_FILT, 500);
      chk("dc_ovf", OVF, 0);
    end

    // impulses at two alignments
    impulse(0, s327, s269, s11, sclip, other);
    chk("imp_centre_327", s327, 1);
    chk("imp_other_ch_zero", other, 0);
    impulse(1, s327, s269, s11, sclip, other);
    chk("imp_tap551_269", s269, 1);
    chk("imp_tap22_11", s11, 1);
    chk("imp_neg_clip", sclip, 1);

    // full-scale step
    a0 = 4095;
    seen_hi = 0;
    for (int i = 0; i < 45; i++) begin
      @(negedge clk);
      if (ADC0_FILT == 4095 && OVF[0]) seen_hi = 1;
    end
    chk("step_overshoot_clip", seen_hi, 1);
    chk("step_settled", ADC0_FILT, 4095);
    chk("step_settled_ovf", OVF[0], 0);

    // SYNC pulse while ENABLE40==1, then held for 5 clocks with moving input
    wait_en(1);
    SYNC = 1; a0 = 12'($urandom);
    @(negedge clk);
    chk("sync_pulse_en0", ENABLE40, 0);
    SYNC = 0;
    for (int i = 1; i <= 3; i++) begin
      a0 = 12'($urandom);
      @(negedge clk);
      chk("sync_resume", ENABLE40, i % 3);
    end
    SYNC = 1;
    for (int i = 0; i < 5; i++) begin
      a0 = 12'($urandom);
      @(negedge clk);
      chk("sync_hold_en0", ENABLE40, 0);
    end
    SYNC = 0;

    // bypass ramp
    BYPASS = 1;
    for (int i = 0; i < 60; i++) begin
      a0 = 12'(i * 7); a1 = 12'(4095 - i); a2 = 12'(i);
      @(negedge clk);
    end
    BYPASS = 0;

    // reset mid-ramp
    for (int i = 0; i < 30; i++) begin a0 = 12'(100 + i * 50); @(negedge clk); end
    RESET = 1;
    @(negedge clk);
    chk("midrst_en", ENABLE40, 0);
    chk("midrst_filt0", ADC0_FILT, 0);
    chk("midrst_ovf", OVF, 0);
    RESET = 0;
    for (int i = 0; i < 40; i++) begin a0 = 12'(1600 + i * 50); @(negedge clk); end

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      a0 = 12'($urandom); a1 = 12'($urandom); a2 = 12'($urandom);
      if ($urandom_range(0, 9) == 0) a0 = ($urandom_range(0, 1) != 0) ? 12'hfff : 12'h000;
      if ($urandom_range(0, 29) == 0) BYPASS = ~BYPASS;
      SYNC  = ($urandom_range(0, 19) == 0);
      RESET = ($urandom_range(0, 149) == 0);
      @(negedge clk);
    end
    SYNC = 0; RESET = 0;
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
